// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer: sequences 4-byte instruction fetches over a byte-wide memory port shared with a program loader
module imem_fetch_sequencer #(
    parameter int unsigned MEM_SIZE     = 4095,
    parameter bit          NOP_ON_FAULT = 1'b0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_valid_i,
    input  logic [63:0] fetch_addr_i,
    output logic        fetch_ready_o,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic        instr_fault_o,
    input  logic        load_valid_i,
    input  logic [63:0] load_addr_i,
    input  logic [7:0]  load_data_i,
    output logic        load_ready_o,
    output logic        mem_rd_en_o,
    output logic        mem_wr_en_o,
    output logic [63:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    localparam logic [63:0] LAST_FETCH = 64'(MEM_SIZE) - 64'd4;
    localparam logic [63:0] MEM_END    = 64'(MEM_SIZE);
    localparam logic [31:0] FAULT_WORD = NOP_ON_FAULT ? 32'h0000_0013 : 32'h0000_0000;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] base_q, base_d;
    logic        pend_q, pend_d;
    logic [1:0]  pend_idx_q, pend_idx_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic        accept;
    logic        req_fault;

    // Next-state, handshakes, memory strobes and byte assembly; reset gates every handshake and strobe
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        shift_d       = shift_q;
        instr_d       = instr_q;
        fault_d       = fault_q;
        pend_idx_d    = cnt_q;
        fetch_ready_o = reset_i && (state_q == IDLE || state_q == RESP);
        load_ready_o  = reset_i && state_q == IDLE && !fetch_valid_i;
        instr_valid_o = reset_i && state_q == RESP;
        mem_rd_en_o   = reset_i && state_q == ISSUE;
        mem_wr_en_o   = load_valid_i && load_ready_o && load_addr_i < MEM_END;
        mem_addr_o    = mem_rd_en_o ? base_q + {62'd0, cnt_q} : mem_wr_en_o ? load_addr_i : 64'd0;
        mem_wdata_o   = mem_wr_en_o ? load_data_i : 8'd0;
        instr_o       = instr_q;
        instr_fault_o = fault_q;
        pend_d        = mem_rd_en_o;
        accept        = fetch_valid_i && fetch_ready_o;
        req_fault     = fetch_addr_i[1:0] != 2'b00 || fetch_addr_i > LAST_FETCH;
        if (pend_q)
            shift_d[{~pend_idx_q, 3'b000} +: 8] = mem_rdata_i;
        case (state_q)
            ISSUE: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3)
                    state_d = WAIT;
            end
            WAIT: begin
                state_d = RESP;
                instr_d = shift_d;
                fault_d = 1'b0;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            base_d  = fetch_addr_i;
            cnt_d   = 2'd0;
            state_d = req_fault ? RESP : ISSUE;
            if (req_fault) begin
                instr_d = FAULT_WORD;
                fault_d = 1'b1;
            end
        end
    end

    // State register; an active-low reset abandons any fetch and discards bytes still in flight
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            base_q     <= 64'd0;
            pend_q     <= 1'b0;
            pend_idx_q <= 2'd0;
            shift_q    <= 32'd0;
            instr_q    <= 32'd0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            shift_q    <= shift_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
        end
    end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// tb_imem_fetch_sequencer: randomized scoreboard bench against a byte-array reference model
module tb_imem_fetch_sequencer;
    localparam int MS = 4095;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [63:0] fetch_addr = 64'd0;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_fault;
    logic        load_valid = 1'b0;
    logic [63:0] load_addr = 64'd0;
    logic [7:0]  load_data = 8'd0;
    logic        load_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'd0;

    logic [7:0]  mem [0:MS-1];
    logic [7:0]  ref_mem [0:MS-1];
    exp_t        q[$];
    int          resp_cyc[$];
    logic [63:0] exp_rd [int];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_instr = 32'd0;
    logic        last_fault = 1'b0;

    imem_fetch_sequencer #(.MEM_SIZE(MS), .NOP_ON_FAULT(1'b1)) dut (
        .clk_i(clk), .reset_i(reset),
        .fetch_valid_i(fetch_valid), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_fault_o(instr_fault),
        .load_valid_i(load_valid), .load_addr_i(load_addr), .load_data_i(load_data), .load_ready_o(load_ready),
        .mem_rd_en_o(mem_rd_en), .mem_wr_en_o(mem_wr_en), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide synchronous-read memory; junk is returned on cycles without a read
    always @(posedge clk) begin
        if (mem_wr_en && mem_addr < 64'(MS))
            mem[int'(mem_addr[31:0])] <= mem_wdata;
        mem_rdata <= (mem_rd_en && mem_addr < 64'(MS)) ? mem[int'(mem_addr[31:0])] : 8'($urandom);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor and reference model: expectations come only from the protocol rules and ref_mem
    always @(negedge clk) begin : monitor
        bit busy, in_resp, exp_fr, exp_lr, exp_wr, exp_rden, f;
        exp_t e;
        int a;
        if (!reset) begin
            q.delete();
            exp_rd.delete();
            check("rst_fetch_ready", fetch_ready, 0);
            check("rst_load_ready", load_ready, 0);
            check("rst_rd_en", mem_rd_en, 0);
            check("rst_wr_en", mem_wr_en, 0);
            last_instr = 32'd0;
            last_fault = 1'b0;
        end else begin
            busy    = q.size() != 0;
            in_resp = busy && q[0].due == cyc;
            exp_fr  = !busy || in_resp;
            exp_lr  = !busy && !fetch_valid;
            exp_wr  = load_valid && exp_lr && load_addr < 64'(MS);
            exp_rden = exp_rd.exists(cyc);
            check("fetch_ready", fetch_ready, exp_fr);
            check("load_ready", load_ready, exp_lr);
            check("rd_en", mem_rd_en, exp_rden);
            check("wr_en", mem_wr_en, exp_wr);
            check("strobe_excl", mem_rd_en & mem_wr_en, 0);
            if (exp_rden) begin
                check("rd_addr", mem_addr, exp_rd[cyc]);
                exp_rd.delete(cyc);
            end else if (exp_wr) begin
                check("wr_addr", mem_addr, load_addr);
                check("wr_data", mem_wdata, load_data);
            end else begin
                check("idle_addr", mem_addr, 0);
                check("idle_wdata", mem_wdata, 0);
            end
            check("instr_valid", instr_valid, in_resp);
            if (busy && (instr_valid || in_resp)) begin
                e = q.pop_front();
                if (instr_valid) begin
                    check("instr", instr, e.instr);
                    check("instr_fault", instr_fault, e.fault);
                    check("resp_cycle", cyc, e.due);
                    resp_cyc.push_back(cyc);
                end
                last_instr = e.instr;
                last_fault = e.fault;
            end else begin
                check("instr_hold", instr, last_instr);
                check("fault_hold", instr_fault, last_fault);
            end
            if (fetch_valid && exp_fr) begin
                f = fetch_addr[1:0] != 2'b00 || fetch_addr > 64'(MS - 4);
                e.fault = f;
                e.due   = cyc + (f ? 1 : 6);
                if (f) e.instr = 32'h0000_0013;
                else begin
                    a = int'(fetch_addr[31:0]);
                    e.instr = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
                    for (int k = 0; k < 4; k++) exp_rd[cyc + 1 + k] = fetch_addr + 64'(k);
                end
                q.push_back(e);
            end
            if (exp_wr) ref_mem[int'(load_addr[31:0])] = load_data;
        end
    end

    task automatic do_load(input logic [63:0] a, input logic [7:0] d);
        bit ok = 0;
        load_addr = a; load_data = d; load_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (load_ready) begin ok = 1; break; end
        end
        if (!ok) check("load_timeout", 0, 1);
        @(posedge clk); #1;
        load_valid = 1'b0;
    endtask

    task automatic do_fetch(input logic [63:0] a);
        bit ok = 0;
        fetch_addr = a; fetch_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (fetch_ready) begin ok = 1; break; end
        end
        if (!ok) check("fetch_timeout", 0, 1);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            if (q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) check("idle_timeout", q.size(), 0);
    endtask

    initial begin
        int n;
        logic [63:0] a;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_instr", instr, 0);
        check("reset_fault", instr_fault, 0);
        check("reset_valid", instr_valid, 0);
        @(posedge clk); #1;
        for (int i = 0; i < MS; i++) do_load(64'(i), 8'($urandom));
        do_load(64'd8, 8'h00); do_load(64'd9, 8'h50); do_load(64'd10, 8'h00); do_load(64'd11, 8'h93);
        do_fetch(64'd8);
        wait_idle();
        check("load_fetch_instr", instr, 32'h0050_0093);
        check("load_fetch_fault", instr_fault, 0);
        n = resp_cyc.size();
        do_fetch(64'd0);
        do_fetch(64'd4);
        wait_idle();
        check("b2b_count", resp_cyc.size(), n + 2);
        if (resp_cyc.size() >= n + 2) check("b2b_gap", resp_cyc[n+1] - resp_cyc[n], 6);
        do_fetch(64'd6);
        do_fetch(64'd4092);
        wait_idle();
        check("fault_instr", instr, 32'h0000_0013);
        check("fault_flag", instr_fault, 1);
        do_fetch(64'd4089);
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC);
        do_fetch(64'd4088);
        wait_idle();
        check("last_legal_fault", instr_fault, 0);
        fetch_addr = 64'd12; fetch_valid = 1'b1;
        load_addr = 64'd20; load_data = 8'h5A; load_valid = 1'b1;
        @(negedge clk);
        check("arb_fetch_ready", fetch_ready, 1);
        check("arb_load_ready", load_ready, 0);
        @(posedge clk); #1;
        fetch_valid = 1'b0;
        do_load(64'd20, 8'h5A);
        wait_idle();
        do_fetch(64'd20);
        wait_idle();
        check("arb_load_landed", instr[31:24], 8'h5A);
        n = resp_cyc.size();
        do_fetch(64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_resp", resp_cyc.size(), n);
        check("midreset_instr", instr, 0);
        do_fetch(64'd0);
        wait_idle();
        check("after_reset_resp", resp_cyc.size(), n + 1);
        do_load(64'd5000, 8'hAA);
        do_fetch(64'd4088);
        wait_idle();
        for (int it = 0; it < 300; it++) begin
            int r = $urandom_range(0, 9);
            if (r < 4) begin
                a = ($urandom_range(0, 9) == 0) ? 64'(MS + $urandom_range(0, 2000)) : 64'($urandom_range(0, MS - 1));
                do_load(a, 8'($urandom));
            end else if (r < 9) begin
                case ($urandom_range(0, 7))
                    0: a = 64'($urandom_range(0, 4094));
                    1: a = 64'($urandom_range(1023, 2000)) << 2;
                    default: a = 64'($urandom_range(0, 1022)) << 2;
                endcase
                do_fetch(a);
            end else begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("final_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
